// File: rtl/ahb2uart_rx.sv
// AHB-Lite slave UART receiver: 8N1 frames from UART_RX are deserialised into a small FIFO read through DATA/STAT.
// Latency: start-bit falling edge to FIFO entry is 3 + CLKS_PER_BIT*9.5 HCLK cycles; zero-wait-state bus access.
// Backpressure: none on the serial side; a byte arriving into a full FIFO is dropped and flagged as overrun.
module ahb2uart_rx #(
    parameter int CLKS_PER_BIT    = 16,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic        HREADY,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    input  logic        UART_RX,
    output logic        RXIRQ
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int PTR_W = FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // Serial side
    logic             rx_meta;
    logic             rxs;
    state_t           state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             push;
    logic             ferr_set;

    // FIFO
    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             pop;
    logic             ovr_set;

    // Bus side
    logic             accept;
    logic             dph_vld;
    logic             dph_write;
    logic [1:0]       dph_addr;
    logic             stat_wr;
    logic             overrun;
    logic             framing;

    // Bits of the bus that carry no meaning for this slave
    logic             unused_bus;
    assign unused_bus = ^{HSIZE, HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:4], HWDATA[1:0]};

    assign HREADYOUT = 1'b1;

    // Two-flop synchroniser; presets to the idle line level so reset never looks like a start bit
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= UART_RX;
            rxs     <= rx_meta;
        end
    end

    // Receive state machine; push and ferr_set are one-cycle registered strobes
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= S_IDLE;
            clk_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            push     <= 1'b0;
            ferr_set <= 1'b0;
        end else begin
            push     <= 1'b0;
            ferr_set <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!rxs) begin
                        // The detecting cycle already counts toward the half-bit wait
                        state   <= S_START;
                        clk_cnt <= CNT_W'(1);
                        bit_cnt <= '0;
                    end
                end
                S_START: begin
                    if (clk_cnt == CNT_W'(HALF - 1)) begin
                        clk_cnt <= '0;
                        state   <= rxs ? S_IDLE : S_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        clk_cnt <= '0;
                        shreg   <= {rxs, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= S_STOP;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        clk_cnt <= '0;
                        if (rxs) begin
                            push  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            ferr_set <= 1'b1;
                            state    <= S_BREAK;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (rxs) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign accept  = HSEL & HREADY & HTRANS[1];
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop     = dph_vld & ~dph_write & (dph_addr == 2'd0) & ~empty;
    assign stat_wr = dph_vld & dph_write & (dph_addr == 2'd1);
    // A simultaneous pop frees the slot, so a full FIFO still accepts the byte
    assign do_push = push & (~full | pop);
    assign ovr_set = push & full & ~pop;

    // Next occupancy, shared by the counter and the interrupt register
    always_comb begin
        count_nxt = count;
        case ({do_push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Register the address phase for use in the following data phase
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dph_vld   <= 1'b0;
            dph_write <= 1'b0;
            dph_addr  <= '0;
        end else begin
            dph_vld   <= accept;
            dph_write <= HWRITE;
            dph_addr  <= HADDR[3:2];
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge HCLK) begin
        if (do_push) begin
            mem[wr_ptr] <= shreg;
        end
    end

    // FIFO pointers, occupancy, sticky flags (set beats clear) and interrupt
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
            framing <= 1'b0;
            RXIRQ   <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count   <= count_nxt;
            overrun <= ovr_set  | (overrun & ~(stat_wr & HWDATA[2]));
            framing <= ferr_set | (framing & ~(stat_wr & HWDATA[3]));
            RXIRQ   <= (count_nxt != '0);
        end
    end

    // Read mux, only driven during a read data phase
    always_comb begin
        HRDATA = '0;
        if (dph_vld && !dph_write) begin
            case (dph_addr)
                2'd0: begin
                    if (!empty) begin
                        HRDATA[7:0] = mem[rd_ptr];
                    end
                end
                2'd1: HRDATA[7:0] = {4'(count), framing, overrun, full, ~empty};
                default: HRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb2uart_rx.sv
module tb_ahb2uart_rx;

    localparam int CPB = 16;

    localparam int OP_SEND = 0;
    localparam int OP_RD   = 1;
    localparam int OP_WR   = 2;
    localparam int OP_IRQ  = 3;
    localparam int OP_BUSY = 4;
    localparam int OP_NSEL = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsel;
    logic        hready;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hreadyout;
    logic [31:0] hrdata;
    logic        uart_rx;
    logic        rxirq;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    ahb2uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(2)) dut (
        .HCLK      (clk),
        .HRESETn   (rst_n),
        .HSEL      (hsel),
        .HREADY    (hready),
        .HADDR     (haddr),
        .HTRANS    (htrans),
        .HWRITE    (hwrite),
        .HSIZE     (hsize),
        .HWDATA    (hwdata),
        .HREADYOUT (hreadyout),
        .HRDATA    (hrdata),
        .UART_RX   (uart_rx),
        .RXIRQ     (rxirq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // All tasks start and end 1ns after a rising edge
    task automatic ahb_rd(input logic [31:0] addr, output logic [31:0] d);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = addr;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; haddr = '0;
        @(negedge clk);
        d = hrdata;
        @(posedge clk); #1;
    endtask

    task automatic ahb_wr(input logic [31:0] addr, input logic [31:0] d);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = addr;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = '0; hwdata = d;
        @(posedge clk); #1;
        hwdata = '0;
    endtask

    // Non-accepted access to DATA; returns whatever HRDATA shows in the following cycle
    task automatic ahb_noop(input logic busy, output logic [31:0] d);
        hsel = busy; htrans = busy ? 2'b01 : 2'b10; hwrite = 1'b0; haddr = 32'h0;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00;
        @(negedge clk);
        d = hrdata;
        @(posedge clk); #1;
    endtask

    // Line is left at the stop-bit level afterwards
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = f[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input int op, input logic [31:0] addr, input logic [31:0] data,
                                input logic [31:0] exp);
        vec_t v;
        v.op = op; v.addr = addr; v.data = data; v.exp = exp;
        return v;
    endfunction

    initial begin
        logic [31:0] d;

        // Single byte, status, pop, interrupt
        vecs.push_back(mk(OP_SEND, 0, 32'hA5, 0));
        vecs.push_back(mk(OP_RD,   4, 0, 32'h11));
        vecs.push_back(mk(OP_IRQ,  0, 0, 1));
        vecs.push_back(mk(OP_RD,   0, 0, 32'hA5));
        vecs.push_back(mk(OP_RD,   4, 0, 32'h00));
        vecs.push_back(mk(OP_IRQ,  0, 0, 0));
        // Empty reads, unmapped offsets, ignored DATA write
        vecs.push_back(mk(OP_RD,   0, 0, 32'h00));
        vecs.push_back(mk(OP_RD,   8, 0, 32'h00));
        vecs.push_back(mk(OP_RD,  12, 0, 32'h00));
        vecs.push_back(mk(OP_WR,   0, 32'hFF, 0));
        vecs.push_back(mk(OP_WR,   8, 32'hFF, 0));
        vecs.push_back(mk(OP_RD,   4, 0, 32'h00));
        // Fill, overrun, non-accepted accesses, drain in order, W1C
        vecs.push_back(mk(OP_SEND, 0, 32'h01, 0));
        vecs.push_back(mk(OP_SEND, 0, 32'h02, 0));
        vecs.push_back(mk(OP_SEND, 0, 32'h03, 0));
        vecs.push_back(mk(OP_SEND, 0, 32'h04, 0));
        vecs.push_back(mk(OP_RD,   4, 0, 32'h43));
        vecs.push_back(mk(OP_SEND, 0, 32'h05, 0));
        vecs.push_back(mk(OP_RD,   4, 0, 32'h47));
        vecs.push_back(mk(OP_BUSY, 0, 0, 32'h00));
        vecs.push_back(mk(OP_NSEL, 0, 0, 32'h00));
        vecs.push_back(mk(OP_RD,   4, 0, 32'h47));
        vecs.push_back(mk(OP_RD,   0, 0, 32'h01));
        vecs.push_back(mk(OP_RD,   0, 0, 32'h02));
        vecs.push_back(mk(OP_RD,   0, 0, 32'h03));
        vecs.push_back(mk(OP_RD,   0, 0, 32'h04));
        vecs.push_back(mk(OP_RD,   4, 0, 32'h04));
        vecs.push_back(mk(OP_WR,   4, 32'hFFFF_FFF3, 0));
        vecs.push_back(mk(OP_RD,   4, 0, 32'h04));
        vecs.push_back(mk(OP_WR,   4, 32'h04, 0));
        vecs.push_back(mk(OP_RD,   4, 0, 32'h00));

        rst_n = 1'b0; uart_rx = 1'b1; hsel = 1'b0; hready = 1'b1; haddr = '0;
        htrans = 2'b00; hwrite = 1'b0; hsize = 3'b010; hwdata = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_hrdata", hrdata, 32'h0);
        check("rst_hreadyout", {31'b0, hreadyout}, 32'h1);
        check("rst_rxirq", {31'b0, rxirq}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_cycles(2);
        ahb_rd(32'h4, d);
        check("rst_stat", d, 32'h0);

        // Table-driven part
        for (int i = 0; i < vecs.size(); i++) begin
            case (vecs[i].op)
                OP_SEND: send_frame(vecs[i].data[7:0], 1'b1);
                OP_RD: begin
                    ahb_rd(vecs[i].addr, d);
                    check($sformatf("vec%0d_rd%0h", i, vecs[i].addr), d, vecs[i].exp);
                end
                OP_WR: ahb_wr(vecs[i].addr, vecs[i].data);
                OP_IRQ: begin
                    @(negedge clk);
                    check($sformatf("vec%0d_irq", i), {31'b0, rxirq}, vecs[i].exp);
                    @(posedge clk); #1;
                end
                default: begin
                    ahb_noop(vecs[i].op == OP_BUSY, d);
                    check($sformatf("vec%0d_noop_hrdata", i), d, vecs[i].exp);
                end
            endcase
        end

        // Glitch shorter than half a bit: rejected, receiver back in IDLE
        uart_rx = 1'b0;
        idle_cycles(4);
        uart_rx = 1'b1;
        idle_cycles(40);
        ahb_rd(32'h4, d);
        check("glitch_stat", d, 32'h00);
        send_frame(8'h66, 1'b1);
        ahb_rd(32'h4, d);
        check("glitch_next_stat", d, 32'h11);
        ahb_rd(32'h0, d);
        check("glitch_next_data", d, 32'h66);

        // Framing error, line held low, then recovery and W1C of bit3
        send_frame(8'hC3, 1'b0);
        idle_cycles(50);
        ahb_rd(32'h4, d);
        check("break_stat", d, 32'h08);
        idle_cycles(100);
        ahb_rd(32'h4, d);
        check("break_held_stat", d, 32'h08);
        uart_rx = 1'b1;
        idle_cycles(20);
        send_frame(8'h5A, 1'b1);
        ahb_rd(32'h4, d);
        check("break_next_stat", d, 32'h19);
        ahb_wr(32'h4, 32'h08);
        ahb_rd(32'h4, d);
        check("ferr_clear_stat", d, 32'h11);
        ahb_rd(32'h0, d);
        check("break_next_data", d, 32'h5A);

        // Pop coincident with a push into a full FIFO. The byte enters the FIFO on
        // the 155th rising edge after the start bit is driven; the read's address
        // phase is placed on edge 154 so its pop lands on the same edge.
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b1);
        fork
            send_frame(8'h55, 1'b1);
            begin
                logic [31:0] dr;
                idle_cycles(153);
                ahb_rd(32'h0, dr);
                check("pushpop_data", dr, 32'h11);
            end
        join
        ahb_rd(32'h4, d);
        check("pushpop_stat", d, 32'h43);
        ahb_rd(32'h0, d);
        check("pushpop_d1", d, 32'h22);
        ahb_rd(32'h0, d);
        check("pushpop_d2", d, 32'h33);
        ahb_rd(32'h0, d);
        check("pushpop_d3", d, 32'h44);
        ahb_rd(32'h0, d);
        check("pushpop_d4", d, 32'h55);
        ahb_rd(32'h4, d);
        check("pushpop_empty", d, 32'h00);

        // Reset during the 5th data bit of an all-ones byte
        send_frame(8'h77, 1'b1);
        @(negedge clk);
        check("prerst_irq", {31'b0, rxirq}, 32'h1);
        @(posedge clk); #1;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                idle_cycles(85);
                rst_n = 1'b0;
                @(negedge clk);
                check("midrst_hrdata", hrdata, 32'h0);
                check("midrst_hreadyout", {31'b0, hreadyout}, 32'h1);
                check("midrst_rxirq", {31'b0, rxirq}, 32'h0);
                idle_cycles(3);
                rst_n = 1'b1;
            end
        join
        idle_cycles(10);
        ahb_rd(32'h4, d);
        check("postrst_stat", d, 32'h00);
        send_frame(8'h3C, 1'b1);
        ahb_rd(32'h4, d);
        check("postrst_stat2", d, 32'h11);
        ahb_rd(32'h0, d);
        check("postrst_data", d, 32'h3C);
        ahb_rd(32'h4, d);
        check("postrst_empty", d, 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
